// File: rtl/prom_seq_pkg.sv
// Shared types and constants for the PROM page-write sequencer.
package prom_seq_pkg;

    localparam int unsigned QUAD_W     = 32;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned BLK_ADDR_W = 6;
    localparam int unsigned ERR_W      = 2;
    localparam int unsigned POLL_W     = 16;
    localparam int unsigned OP_W       = 8;

    // SPI PROM opcodes carried in the top byte of a command quadlet
    localparam logic [OP_W-1:0] OP_WREN  = 8'h06;
    localparam logic [OP_W-1:0] OP_RDSR  = 8'h05;
    localparam logic [OP_W-1:0] OP_WRITE = 8'h02;

    // Failure reasons reported with done
    localparam logic [ERR_W-1:0] ERR_NQUADS  = 2'd0;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [ERR_W-1:0] ERR_COUNT   = 2'd2;
    localparam logic [ERR_W-1:0] ERR_POLLS   = 2'd3;

    // PROM interface status / result layout
    localparam logic [2:0]  PROM_ST_IDLE = 3'd0;
    localparam int unsigned ST_BLK_WRT   = 3;
    localparam int unsigned RES_WIP      = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_WREN_W,
        S_BSTART,
        S_BDATA,
        S_BEND,
        S_BWAIT,
        S_RDSR,
        S_RDSR_W,
        S_GAP,
        S_FIN
    } seq_state_t;

    // PROM interface can accept a new command
    function automatic logic prom_is_idle(input logic [QUAD_W-1:0] status);
        return (status[2:0] == PROM_ST_IDLE) && !status[ST_BLK_WRT];
    endfunction

    // Single-opcode register command quadlet
    function automatic logic [QUAD_W-1:0] reg_cmd(input logic [OP_W-1:0] op);
        return {op, 24'h00_0000};
    endfunction

endpackage

// File: rtl/prom_op_wait.sv
// Busy-then-idle wait with watchdog, shared by every PROM wait state.
import prom_seq_pkg::*;

module prom_op_wait #(
    parameter int unsigned WAIT_TIMEOUT = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic en,
    input  logic prom_busy,
    input  logic prom_idle,
    output logic done_c,
    output logic timeout_c
);

    localparam int unsigned WD_W = $clog2(WAIT_TIMEOUT + 1);

    logic            seen_busy;
    logic [WD_W-1:0] wdog;

    // Track whether the operation ever went busy and how long we have waited
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_busy <= 1'b0;
            wdog      <= '0;
        end else if (go) begin
            seen_busy <= 1'b0;
            wdog      <= '0;
        end else if (en) begin
            if (prom_busy) begin
                seen_busy <= 1'b1;
            end
            if (wdog != WD_W'(WAIT_TIMEOUT)) begin
                wdog <= wdog + WD_W'(1);
            end
        end
    end

    assign done_c    = en && seen_busy && prom_idle;
    assign timeout_c = en && !done_c && (wdog == WD_W'(WAIT_TIMEOUT));

endmodule

// File: rtl/prom_write_seq.sv
// Buffers one page-write frame and drives WREN, block write and status polling.
import prom_seq_pkg::*;

module prom_write_seq #(
    parameter int unsigned MAX_QUADS    = 17,
    parameter int unsigned WAIT_TIMEOUT = 4095,
    parameter int unsigned POLL_GAP     = 1000,
    parameter int unsigned MAX_POLLS    = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_wen,
    input  logic [IDX_W-1:0]      ld_addr,
    input  logic [QUAD_W-1:0]     ld_data,
    input  logic [IDX_W-1:0]      nquads,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ERR_W-1:0]      err_code,
    output logic [POLL_W-1:0]     poll_count,
    output logic                  seq_active,
    output logic [QUAD_W-1:0]     prom_cmd,
    output logic                  prom_reg_wen,
    output logic                  prom_blk_start,
    output logic                  prom_blk_wen,
    output logic [BLK_ADDR_W-1:0] prom_blk_addr,
    output logic                  prom_blk_end,
    input  logic [QUAD_W-1:0]     prom_status,
    input  logic [QUAD_W-1:0]     prom_result
);

    localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

    seq_state_t            state, state_d;
    logic [QUAD_W-1:0]     qbuf [MAX_QUADS];
    logic [IDX_W-1:0]      nq, nq_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [GAP_W-1:0]      gap, gap_d;

    logic                  busy_d, done_d, error_d;
    logic [ERR_W-1:0]      err_code_d;
    logic [POLL_W-1:0]     poll_count_d;
    logic [QUAD_W-1:0]     prom_cmd_d;
    logic                  reg_wen_d, blk_start_d, blk_wen_d, blk_end_d;
    logic [BLK_ADDR_W-1:0] blk_addr_d;

    logic                  wait_go_c, wait_en_c, wait_done_c, wait_timeout_c;
    logic                  prom_idle_c, prom_busy_c;
    logic                  unused_bits;

    assign prom_idle_c = prom_is_idle(prom_status);
    assign prom_busy_c = (prom_status[2:0] != PROM_ST_IDLE);
    assign seq_active  = busy;
    assign unused_bits = ^{prom_status[QUAD_W-1:4], prom_result[QUAD_W-1:7]};

    prom_op_wait #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .go        (wait_go_c),
        .en        (wait_en_c),
        .prom_busy (prom_busy_c),
        .prom_idle (prom_idle_c),
        .done_c    (wait_done_c),
        .timeout_c (wait_timeout_c)
    );

    // Frame buffer: loadable only between sequences
    always_ff @(posedge clk) begin
        if (state == S_IDLE && ld_wen && ld_addr < IDX_W'(MAX_QUADS)) begin
            qbuf[ld_addr] <= ld_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            nq             <= '0;
            idx            <= '0;
            gap            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= '0;
            poll_count     <= '0;
            prom_cmd       <= '0;
            prom_reg_wen   <= 1'b0;
            prom_blk_start <= 1'b0;
            prom_blk_wen   <= 1'b0;
            prom_blk_addr  <= '0;
            prom_blk_end   <= 1'b0;
        end else begin
            state          <= state_d;
            nq             <= nq_d;
            idx            <= idx_d;
            gap            <= gap_d;
            busy           <= busy_d;
            done           <= done_d;
            error          <= error_d;
            err_code       <= err_code_d;
            poll_count     <= poll_count_d;
            prom_cmd       <= prom_cmd_d;
            prom_reg_wen   <= reg_wen_d;
            prom_blk_start <= blk_start_d;
            prom_blk_wen   <= blk_wen_d;
            prom_blk_addr  <= blk_addr_d;
            prom_blk_end   <= blk_end_d;
        end
    end

    // Sequencing: next state and next output values
    always_comb begin
        state_d      = state;
        nq_d         = nq;
        idx_d        = idx;
        gap_d        = gap;
        busy_d       = busy;
        done_d       = 1'b0;
        error_d      = error;
        err_code_d   = err_code;
        poll_count_d = poll_count;
        prom_cmd_d   = prom_cmd;
        reg_wen_d    = 1'b0;
        blk_start_d  = 1'b0;
        blk_wen_d    = 1'b0;
        blk_addr_d   = prom_blk_addr;
        blk_end_d    = 1'b0;
        wait_go_c    = 1'b0;
        wait_en_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    nq_d = nquads;
                    if (nquads == '0 || nquads > IDX_W'(MAX_QUADS)) begin
                        done_d     = 1'b1;
                        error_d    = 1'b1;
                        err_code_d = ERR_NQUADS;
                    end else begin
                        busy_d       = 1'b1;
                        poll_count_d = '0;
                        error_d      = 1'b0;
                        err_code_d   = ERR_NQUADS;
                        state_d      = S_WREN;
                    end
                end
            end

            S_WREN: begin
                if (prom_idle_c) begin
                    prom_cmd_d = reg_cmd(OP_WREN);
                    reg_wen_d  = 1'b1;
                    wait_go_c  = 1'b1;
                    state_d    = S_WREN_W;
                end
            end

            S_WREN_W: begin
                wait_en_c = 1'b1;
                if (wait_done_c) begin
                    state_d = S_BSTART;
                end else if (wait_timeout_c) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FIN;
                end
            end

            S_BSTART: begin
                if (prom_idle_c) begin
                    blk_start_d = 1'b1;
                    idx_d       = '0;
                    state_d     = S_BDATA;
                end
            end

            // Gap-free burst: the PROM side ends the block if its reader catches up
            S_BDATA: begin
                blk_wen_d  = 1'b1;
                blk_addr_d = BLK_ADDR_W'(idx);
                prom_cmd_d = qbuf[idx];
                idx_d      = idx + IDX_W'(1);
                if (idx == nq - IDX_W'(1)) begin
                    state_d = S_BEND;
                end
            end

            S_BEND: begin
                blk_end_d = 1'b1;
                wait_go_c = 1'b1;
                state_d   = S_BWAIT;
            end

            S_BWAIT: begin
                wait_en_c = 1'b1;
                if (wait_done_c) begin
                    if (prom_result[6:0] != 7'(nq)) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_COUNT;
                        state_d    = S_FIN;
                    end else begin
                        state_d = S_RDSR;
                    end
                end else if (wait_timeout_c) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FIN;
                end
            end

            S_RDSR: begin
                if (prom_idle_c) begin
                    prom_cmd_d = reg_cmd(OP_RDSR);
                    reg_wen_d  = 1'b1;
                    wait_go_c  = 1'b1;
                    if (poll_count != '1) begin
                        poll_count_d = poll_count + POLL_W'(1);
                    end
                    state_d = S_RDSR_W;
                end
            end

            S_RDSR_W: begin
                wait_en_c = 1'b1;
                if (wait_done_c) begin
                    if (!prom_result[RES_WIP]) begin
                        state_d = S_FIN;
                    end else if (poll_count == POLL_W'(MAX_POLLS)) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_POLLS;
                        state_d    = S_FIN;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (wait_timeout_c) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FIN;
                end
            end

            S_GAP: begin
                gap_d = gap + GAP_W'(1);
                if (gap >= GAP_W'(POLL_GAP - 1)) begin
                    state_d = S_RDSR;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prom_write_seq.sv
// Directed bench for prom_write_seq with a behavioural PROM interface model.
module tb_prom_write_seq;

    localparam int unsigned MAXQ = 17;
    localparam int unsigned WT   = 4095;
    localparam int unsigned PG   = 40;
    localparam int unsigned MP   = 4;

    localparam int M_OK = 0, M_DEAD = 1, M_BAD = 2, M_STUCK = 3;
    localparam int EV_WREN = 1, EV_BSTART = 2, EV_BLK = 3, EV_BEND = 4, EV_RDSR = 5, EV_UNK = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_wen;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [4:0]  nquads;
    logic        start;
    logic        busy, done, error, seq_active;
    logic [1:0]  err_code;
    logic [15:0] poll_count;
    logic [31:0] prom_cmd;
    logic        prom_reg_wen, prom_blk_start, prom_blk_wen, prom_blk_end;
    logic [5:0]  prom_blk_addr;
    logic [31:0] prom_status, prom_result;

    prom_write_seq #(
        .MAX_QUADS(MAXQ), .WAIT_TIMEOUT(WT), .POLL_GAP(PG), .MAX_POLLS(MP)
    ) dut (
        .clk(clk), .reset(reset), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data),
        .nquads(nquads), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .poll_count(poll_count), .seq_active(seq_active),
        .prom_cmd(prom_cmd), .prom_reg_wen(prom_reg_wen), .prom_blk_start(prom_blk_start),
        .prom_blk_wen(prom_blk_wen), .prom_blk_addr(prom_blk_addr), .prom_blk_end(prom_blk_end),
        .prom_status(prom_status), .prom_result(prom_result)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [32];

    // PROM interface model state
    int mode, busy_cnt, polls_seen, blk_cnt;
    bit blk_wrt;

    // Expected PROM-side event stream for the current sequence
    int          exp_kind [64];
    logic [5:0]  exp_addr [64];
    logic [31:0] exp_data [64];
    int          exp_n, rd_ptr, act_n, last_rdsr;
    bit          prev_blk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input logic [5:0] a, input logic [31:0] d);
        exp_kind[exp_n] = kind;
        exp_addr[exp_n] = a;
        exp_data[exp_n] = d;
        exp_n++;
    endtask

    task automatic exp_none();
        exp_n = 0; rd_ptr = 0; act_n = 0; last_rdsr = -1;
    endtask

    // Event stream implied by the mode: WREN, burst, then polls
    task automatic build_exp(input int n, input int md, input int npolls);
        exp_none();
        mode = md;
        push_ev(EV_WREN, 6'd0, 32'h0600_0000);
        if (md == M_DEAD) return;
        push_ev(EV_BSTART, 6'd0, 32'h0);
        for (int i = 0; i < n; i++) push_ev(EV_BLK, 6'(i), mem[i]);
        push_ev(EV_BEND, 6'd0, 32'h0);
        if (md == M_BAD) return;
        for (int i = 0; i < npolls; i++) push_ev(EV_RDSR, 6'd0, 32'h0500_0000);
    endtask

    // One clock: compare DUT outputs on the falling edge, then advance the PROM model
    task automatic tick();
        int kind, nstb;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            busy_cnt = 0; blk_wrt = 0; blk_cnt = 0; polls_seen = 0; prev_blk = 0;
            prom_status = '0; prom_result = '0;
            return;
        end
        chk("seq_active vs busy", seq_active, busy);
        nstb = int'(prom_reg_wen) + int'(prom_blk_start) + int'(prom_blk_wen) + int'(prom_blk_end);
        if (nstb != 0) begin
            if (nstb > 1) chk("single strobe", nstb, 1);
            if (prom_reg_wen)
                kind = (prom_cmd[31:24] == 8'h06) ? EV_WREN :
                       (prom_cmd[31:24] == 8'h05) ? EV_RDSR : EV_UNK;
            else if (prom_blk_start) kind = EV_BSTART;
            else if (prom_blk_wen)   kind = EV_BLK;
            else                     kind = EV_BEND;
            if (prom_reg_wen) chk("reg cmd low bytes", prom_cmd[23:0], 0);
            if (prom_reg_wen || prom_blk_start) chk("strobe needs idle prom", prom_status[3:0], 0);
            if (prom_blk_wen) chk("burst contiguous", prev_blk, 1);
            if (kind == EV_RDSR) begin
                if (last_rdsr >= 0) chk("poll gap", (cyc - last_rdsr) >= int'(PG), 1);
                last_rdsr = cyc;
            end
            act_n++;
            if (rd_ptr < exp_n) begin
                chk("event kind", kind, exp_kind[rd_ptr]);
                if (kind == EV_BLK) begin
                    chk("blk addr", prom_blk_addr, exp_addr[rd_ptr]);
                    chk("blk data", prom_cmd, exp_data[rd_ptr]);
                end
                rd_ptr++;
            end else begin
                chk("extra strobe", kind, 0);
            end
        end
        prev_blk = prom_blk_start || prom_blk_wen;

        if (busy_cnt > 0) busy_cnt--;
        if (prom_reg_wen) begin
            if (mode != M_DEAD) busy_cnt = 8;
            if (prom_cmd[31:24] == 8'h06) polls_seen = 0;
            if (prom_cmd[31:24] == 8'h05) begin
                polls_seen++;
                prom_result = {31'b0, (mode == M_STUCK) || (polls_seen < 3)};
            end
        end
        if (prom_blk_start) begin blk_wrt = 1; blk_cnt = 0; end
        if (prom_blk_wen) blk_cnt++;
        if (prom_blk_end) begin
            blk_wrt = 0;
            busy_cnt = 30;
            prom_result = 32'((mode == M_BAD) ? blk_cnt - 1 : blk_cnt);
        end
        prom_status = {28'b0, blk_wrt, (busy_cnt > 0) ? 3'd2 : 3'd0};
    endtask

    task automatic load(input int i, input logic [31:0] v);
        ld_wen = 1; ld_addr = 5'(i); ld_data = v; mem[i] = v;
        tick();
        ld_wen = 0;
    endtask

    task automatic start_seq(input int n);
        nquads = 5'(n); start = 1;
        tick();
        start = 0;
    endtask

    task automatic finish_seq(input int budget, input int e_err, input int e_code,
                              input int e_polls, input int e_events, output int cycles);
        cycles = 1;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("done seen", done, 1);
        chk("error", error, e_err);
        chk("err_code", err_code, e_code);
        chk("poll_count", poll_count, e_polls);
        chk("busy low at done", busy, 0);
        tick();
        chk("done one cycle", done, 0);
        chk("events issued", act_n, e_events);
        chk("expected events consumed", rd_ptr, exp_n);
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, error, err_code, poll_count, seq_active, prom_cmd,
                prom_reg_wen, prom_blk_start, prom_blk_wen, prom_blk_addr, prom_blk_end};
    endfunction

    initial begin
        int  cycles;
        bit  found, saw_done;
        reset = 0; ld_wen = 0; ld_addr = '0; ld_data = '0; nquads = '0; start = 0;
        prom_status = '0; prom_result = '0; mode = M_OK;
        exp_none();
        tick(); tick();
        chk("outputs in reset", all_outs(), 64'h0);
        reset = 1;
        tick();
        chk("outputs after reset release", all_outs(), 64'h0);

        // Illegal frame lengths: immediate rejection, no PROM traffic
        exp_none();
        start_seq(0);
        finish_seq(10, 1, 0, 0, 0, cycles);
        chk("nquads=0 done latency", cycles, 1);
        exp_none();
        start_seq(18);
        finish_seq(10, 1, 0, 0, 0, cycles);
        chk("nquads=18 done latency", cycles, 1);

        // Full page; last quadlet loaded in the same cycle as start
        for (int i = 0; i < 16; i++) load(i, 32'hA000_0000 + 32'(i) * 32'h0101_0101);
        mem[0] = 32'h0201_005A;
        ld_wen = 1; ld_addr = 5'd0; ld_data = mem[0]; tick(); ld_wen = 0;
        mem[16] = 32'h1234_5678;
        build_exp(17, M_OK, 3);
        ld_wen = 1; ld_addr = 5'd16; ld_data = mem[16]; nquads = 5'd17; start = 1;
        tick();
        ld_wen = 0; start = 0;
        repeat (5) tick();
        ld_wen = 1; ld_addr = 5'd1; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_wen = 0;
        finish_seq(3000, 0, 0, 3, 23, cycles);

        // PROM never goes busy after WREN: watchdog expiry
        build_exp(3, M_DEAD, 0);
        start_seq(3);
        finish_seq(6000, 1, 1, 0, 1, cycles);
        chk("timeout latency window", (cycles >= int'(WT)) && (cycles <= int'(WT) + 16), 1);

        // Block count reported short by one
        build_exp(6, M_BAD, 0);
        start_seq(6);
        finish_seq(3000, 1, 2, 0, 9, cycles);

        // WIP never clears: stop after MAX_POLLS polls (index 1 must be unchanged)
        build_exp(2, M_STUCK, int'(MP));
        start_seq(2);
        finish_seq(3000, 1, 3, 4, 9, cycles);

        // Reset in the middle of the burst aborts silently
        build_exp(17, M_OK, 3);
        start_seq(17);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (prom_blk_wen && prom_blk_addr == 6'd5) found = 1;
        end
        chk("reached burst index 5", found, 1);
        reset = 0;
        #1;
        chk("outputs cleared by mid-burst reset", all_outs(), 64'h0);
        saw_done = 0;
        repeat (3) begin
            tick();
            saw_done = saw_done | done;
        end
        chk("no done after abort", saw_done, 0);
        reset = 1;

        // Fresh sequence after the abort
        build_exp(4, M_OK, 3);
        start_seq(4);
        finish_seq(3000, 0, 0, 3, 10, cycles);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prom_write_seq.md
Name: prom_write_seq

Overview:
Autonomous write sequencer that sits directly upstream of the 25AA128 SPI PROM interface and drives its command and block-write inputs in place of Firewire. It buffers one page-write frame of quadlets, then issues Write Enable (0x06), bursts the frame through the block-write path, and polls Read Status (0x05) until WIP clears. It reports done/error to the parent. A parent mux selects its PROM-side outputs while seq_active=1.

Parameters:
MAX_QUADS, 17, buffer depth in quadlets (header + 64-byte page); legal nquads is 1..MAX_QUADS
WAIT_TIMEOUT, 4095, max clk cycles for any single PROM operation (busy-then-idle)
POLL_GAP, 1000, idle clk cycles between successive status polls
MAX_POLLS, 65535, status polls before giving up

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ld_wen  in  1  buffer load strobe; ignored while busy
ld_addr  in  5  buffer index for ld_data
ld_data  in  32  quadlet; index 0 = {8'h02, addr[15:0], byte0}, formatted by caller
nquads  in  5  quadlets in frame, sampled at start
start  in  1  one-cycle request; ignored while busy
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of every accepted or rejected start
error  out  1  valid with done; held until next start
err_code  out  2  0 bad nquads, 1 timeout, 2 count mismatch, 3 poll limit
poll_count  out  16  status polls issued by last sequence
seq_active  out  1  parent mux select (= busy)
prom_cmd  out  32  command / block quadlet to PROM interface
prom_reg_wen  out  1  quadlet command strobe
prom_blk_start  out  1  block-write start strobe
prom_blk_wen  out  1  block quadlet strobe
prom_blk_addr  out  6  block quadlet index
prom_blk_end  out  1  block-write end strobe
prom_status  in  32  PROM interface status; [2:0] state, [3] blk_wrt
prom_result  in  32  PROM interface result register

Behaviour:
- All outputs registered. Reset: every output 0, buffer contents don't-care, FSM in S_IDLE. Reset mid-sequence aborts without a done pulse. The PROM interface shares the same reset.
- PROM is idle when prom_status[2:0]==0 and prom_status[3]==0. Strobes are asserted for exactly one cycle and only when the PROM is idle, except blk_wen/blk_end inside a burst.
- Wait procedure W: clear seen_busy and watchdog. Set seen_busy on the first cycle with prom_status[2:0]!=0. Exit when seen_busy and idle. If the watchdog reaches WAIT_TIMEOUT: err_code 1, go to S_FIN.
- S_IDLE:
  - ld_wen writes buf[ld_addr] when ld_addr<MAX_QUADS.
  - On start, latch nquads. If 0 or >MAX_QUADS: done=1, error=1, err_code=0, stay idle. Else busy=1, poll_count=0, go to S_WREN.
- S_WREN: when PROM idle, prom_cmd=32'h0600_0000, reg_wen=1 -> S_WREN_W (W).
- S_BSTART: blk_start=1 -> S_BDATA next cycle.
- S_BDATA: one quadlet per consecutive cycle, no gaps. blk_wen=1, blk_addr=i, prom_cmd=buf[i], i=0..nquads-1. Then S_BEND.
  - Gaps are forbidden: the PROM interface ends the burst when its reader catches the writer.
- S_BEND: blk_end=1 -> S_BWAIT (W).
  - On exit, require prom_result[6:0]==nquads, else err_code 2 -> S_FIN.
- S_RDSR: prom_cmd=32'h0500_0000, reg_wen=1, poll_count+1 -> S_RDSR_W (W).
  - On exit, WIP=prom_result[0]. WIP=0 -> S_FIN, success.
  - WIP=1: if poll_count==MAX_POLLS, err_code 3 -> S_FIN; else S_GAP.
- S_GAP: count POLL_GAP cycles -> S_RDSR.
- S_FIN: done=1, error set per path, busy=0 -> S_IDLE.
- Latency, success path: WREN ~20 clk; burst nquads+2 clk plus SPI time 64*nquads clk; each poll ~20 clk + POLL_GAP.
- Simultaneous ld_wen and start in S_IDLE: the load completes and start uses the new nquads; the buffer is read only from the next cycle.
- poll_count saturates at 16'hFFFF.

Decomposition:
- Package prom_seq_pkg: state enum, opcode constants (OP_WREN 8'h06, OP_RDSR 8'h05, OP_WRITE 8'h02), err_code constants, PROM idle-state encoding, status bit indices.
- One sub-module prom_op_wait: implements procedure W (go/idle inputs, done/timeout outputs, WAIT_TIMEOUT parameter), shared by all three wait states.

Test Plan:
- Load 17 quadlets, nquads=17, PROM model clears WIP after 3 polls -> order WREN, 17 consecutive blk_wen with addr 0..16, blk_end, 3 RDSR. Then done=1, error=0, poll_count=3.
- start with nquads=0, then with nquads=18 -> done the following cycle, error=1, err_code=0, no PROM strobe ever asserted.
- PROM model never leaves state 0 after WREN -> done after WAIT_TIMEOUT+small cycles, err_code=1.
- Model returns prom_result[6:0]=5 for nquads=6 -> err_code=2, no RDSR issued.
- MAX_POLLS=4, WIP stuck at 1 -> exactly 4 RDSR commands, err_code=3, poll_count=4.
- Reset asserted during S_BDATA -> all outputs 0 next edge, no done. A fresh start afterwards completes normally.
